// File: rtl/countdown_pkg.sv
// Shared types for the cascaded countdown timer.
package countdown_pkg;

  // Control FSM states of the countdown timer.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/down_digit.sv
// One decrementing digit: loads a clamped preset, counts down when enabled,
// and wraps 0 -> MAX with a combinational borrow on the wrapping cycle.
module down_digit
  import countdown_pkg::*;
#(
  parameter int N   = 4,
  parameter int MAX = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [N-1:0] ld_val,
  input  logic         en,
  output logic [N-1:0] count,
  output logic         borrow
);

  localparam logic [N-1:0] MAX_V = N'(MAX);

  // Digit register: load has priority over decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (ld) begin
      count <= (ld_val > MAX_V) ? MAX_V : ld_val;
    end else if (en) begin
      count <= (count == '0) ? MAX_V : (count - N'(1));
    end
  end

  // Borrow fires in the same cycle the digit wraps, so the next digit
  // decrements on the same edge.
  always_comb begin
    borrow = en && (count == '0);
  end

endmodule

// File: rtl/countdown_chain.sv
// Two-digit cascaded down-counter timer with load/start/pause/expiry control.
// Low digit borrows from the high digit; outputs are all registered.
module countdown_chain
  import countdown_pkg::*;
#(
  parameter int N    = 4,
  parameter int MAX0 = 5,
  parameter int MAX1 = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         load,
  input  logic [N-1:0] load0,
  input  logic [N-1:0] load1,
  input  logic         start,
  input  logic         pause,
  output logic [N-1:0] count0,
  output logic [N-1:0] count1,
  output logic         borrow0,
  output logic         done,
  output logic         expired,
  output logic         busy
);

  state_t state_reg;
  state_t state_next;
  logic   done_next;
  logic   run_tick;
  logic   borrow_lo;
  logic   borrow_hi;
  logic   zero;
  logic   last;

  // Count sits at 0:0, or one tick away from it.
  always_comb begin
    zero = (count0 == '0) && (count1 == '0);
    last = (count0 == N'(1)) && (count1 == '0);
  end

  down_digit #(.N(N), .MAX(MAX0)) u_digit0 (
    .clk    (clk),
    .rst    (rst),
    .ld     (load),
    .ld_val (load0),
    .en     (run_tick),
    .count  (count0),
    .borrow (borrow_lo)
  );

  down_digit #(.N(N), .MAX(MAX1)) u_digit1 (
    .clk    (clk),
    .rst    (rst),
    .ld     (load),
    .ld_val (load1),
    .en     (borrow_lo),
    .count  (count1),
    .borrow (borrow_hi)
  );

  // Next-state and decrement qualification; load > start > pause > tick.
  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    run_tick   = 1'b0;
    if (load) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, PAUSED: begin
          if (start) begin
            if (zero) begin
              state_next = DONE;
              done_next  = 1'b1;
            end else begin
              state_next = RUN;
            end
          end
        end
        RUN: begin
          if (pause) begin
            state_next = PAUSED;
          end else if (tick && !zero) begin
            run_tick = 1'b1;
            if (last) begin
              state_next = DONE;
              done_next  = 1'b1;
            end
          end
          // A high-digit wrap would mean counting below zero; the zero guard
          // prevents it, but park the timer in DONE should it ever happen.
          if (borrow_hi) begin
            state_next = DONE;
          end
        end
        DONE: begin
          state_next = DONE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State register plus the one-cycle done/borrow pulses aligned with counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      done      <= 1'b0;
      borrow0   <= 1'b0;
    end else begin
      state_reg <= state_next;
      done      <= done_next;
      borrow0   <= borrow_lo;
    end
  end

  // Status levels decoded straight from the state register.
  always_comb begin
    busy    = (state_reg == RUN);
    expired = (state_reg == DONE);
  end

endmodule
